weight_bsg_seq: RTL and testbench
=================================

WEIGHT_BSG_SEQ -- requirements
Module: weight_bsg_seq

Interface
REQ-001 Parameter: DIM_OUT, default 16, number of output neurons (weight rows).
REQ-002 Parameter: DIM_IN, default 110, number of inputs per neuron (weight columns).
REQ-003 Parameter: INWD, default 8, unsigned weight width; the stream length per fold is 2^INWD cycles.
REQ-004 Parameter: FOLD, default 4, number of row groups streamed in sequence.
  - Power of 2 that divides DIM_OUT.
  - LOG_FOLD = max(1, clog2(FOLD)).
REQ-005 Port: clk, in, 1, single clock; all logic is on the rising edge.
REQ-006 Port: rst, in, 1, synchronous, active-high reset.
REQ-007 Port: start, in, 1, request to begin a frame.
REQ-008 Port: weight_in, in, DIM_OUT*DIM_IN*INWD, packed weights; row r, column i sits at bits [(r*DIM_IN+i)*INWD +: INWD].
REQ-009 Port: out_ready, in, 1, consumer accepts the current beat.
REQ-010 Port: out_valid, out, 1, out_bits holds a valid beat.
REQ-011 Port: out_bits, out, (DIM_OUT/FOLD)*DIM_IN, temporal bitstream beat; bit [o*DIM_IN+i] belongs to row f*DIM_OUT/FOLD+o.
REQ-012 Port: out_fold, out, LOG_FOLD, current fold index f.
REQ-013 Port: out_cnt, out, INWD, current temporal count c.
REQ-014 Port: out_last, out, 1, the beat is the final beat of the current fold.
REQ-015 Port: busy, out, 1, the block is in the RUN state.
REQ-016 Port: done, out, 1, one-cycle pulse when the frame completes.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE on the final accepted beat.
  - DONE -> IDLE unconditionally after one cycle.
REQ-018 On start in IDLE, the block SHALL latch weight_in into an internal DIM_OUT*DIM_IN*INWD register and set f=0, c=0; later changes to weight_in SHALL NOT affect the frame.
REQ-019 start in RUN or DONE SHALL be ignored: no relatch and no restart.
REQ-020 out_valid SHALL equal 1 exactly while in RUN; the first beat is presented the cycle after start is sampled.
REQ-021 out_bits[o*DIM_IN+i] SHALL equal (W[f*DIM_OUT/FOLD+o][i] > c), an unsigned compare against the latched weights, combinational from registered f, c and weights.
REQ-022 A beat SHALL transfer when out_valid && out_ready; f and c SHALL hold when out_ready=0.
REQ-023 On a transfer with c < 2^INWD-1, c SHALL increment by 1.
REQ-024 On a transfer with c = 2^INWD-1 and f < FOLD-1, c SHALL wrap to 0 and f SHALL increment.
REQ-025 On a transfer with c = 2^INWD-1 and f = FOLD-1, the block SHALL enter DONE.
REQ-026 out_last SHALL equal out_valid && (c == 2^INWD-1).
REQ-027 done SHALL be 1 only in DONE.
  - The frame takes exactly FOLD*2^INWD transfers.
  - With out_ready held at 1, done asserts FOLD*2^INWD+1 cycles after start is sampled.
REQ-028 start asserted in the DONE cycle SHALL be ignored; the next frame may start from IDLE on the following cycle.
REQ-029 Boundary: a weight of 0 SHALL yield 0 ones per fold; a weight of 2^INWD-1 SHALL yield 2^INWD-1 ones per fold (ones-count equals the weight value).
REQ-030 When FOLD=1, out_fold SHALL be constant 0 and the frame SHALL be 2^INWD beats.
REQ-031 busy SHALL equal (state == RUN).

Reset
REQ-032 When rst=1 at a clock edge, the following SHALL hold on the next cycle regardless of state, including mid-frame:
  - state = IDLE, f = 0, c = 0.
  - out_valid, out_last, busy and done = 0.
REQ-033 The latched weight register is not reset; out_bits is don't-care while out_valid=0.
REQ-034 rst SHALL take priority over start in the same cycle.

Verification
All scenarios use DIM_OUT=4, DIM_IN=2, INWD=3, FOLD=2.
REQ-035 Set W[r][i]=r*2+i and hold out_ready=1, then pulse start.
  - Response: 16 valid beats, with out_fold = 0 for beats 0-7 and 1 for beats 8-15.
  - Response: the ones-count of each bit per fold equals its weight, e.g. row 3 col 1 = 7 ones.
  - Response: out_last on beats 7 and 15; done at cycle 17.
REQ-036 Toggle out_ready 1,0,1,0,... during a frame.
  - Response: c and f advance only on transfer cycles.
  - Response: the same 16-beat bit sequence as REQ-035; done is delayed accordingly.
REQ-037 Change weight_in and re-pulse start at beat 5.
  - Response: no restart, and the output remains per the original weights.
REQ-038 Assert rst at beat 10.
  - Response: next cycle out_valid=0, busy=0, done=0, and no done pulse follows.
  - Response: a subsequent start runs a full 16-beat frame.
REQ-039 Use all weights = 0, then all weights = 7.
  - Response: out_bits is all-0 for every beat in the first case.
  - Response: out_bits is all-1 except the beats with c=7 (all-0) in the second case.
REQ-040 Assert start during the done cycle, then assert start one cycle later.
  - Response: the first start is ignored; the second starts a frame and out_valid rises the next cycle.

Source files
------------

// File: rtl/weight_bsg_seq.sv
// Weight-to-bitstream sequencer: latches a weight matrix on start, then streams
// unary/thermometer beats (w > c) per row group, fold by fold, with ready/valid flow control.
module weight_bsg_seq #(
    parameter int DIM_OUT = 16,
    parameter int DIM_IN  = 110,
    parameter int INWD    = 8,
    parameter int FOLD    = 4,
    localparam int LOG_FOLD = (FOLD > 1) ? $clog2(FOLD) : 1,
    localparam int RPF      = DIM_OUT / FOLD,
    localparam int BEAT_W   = RPF * DIM_IN,
    localparam int GRP_W    = BEAT_W * INWD
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [DIM_OUT*DIM_IN*INWD-1:0]   weight_in,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [BEAT_W-1:0]                out_bits,
    output logic [LOG_FOLD-1:0]              out_fold,
    output logic [INWD-1:0]                  out_cnt,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                      r_state, w_nxt;
    logic [LOG_FOLD-1:0]         r_f;
    logic [INWD-1:0]             r_c;
    // Rows of one fold are contiguous in the packed input, so a fold is one slice.
    logic [FOLD-1:0][GRP_W-1:0]  r_w;
    logic [GRP_W-1:0]            w_grp;
    logic                        w_xfer, w_c_max, w_f_max, w_start;

    assign w_start = (r_state == IDLE) && start;
    assign w_xfer  = (r_state == RUN) && out_ready;
    assign w_c_max = &r_c;
    assign w_f_max = (r_f == LOG_FOLD'(FOLD - 1));

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_nxt = RUN;
            RUN:     if (w_xfer && w_c_max && w_f_max) w_nxt = DONE;
            DONE:    w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_f     <= '0;
            r_c     <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_start) begin
                r_f <= '0;
                r_c <= '0;
            end else if (w_xfer) begin
                if (!w_c_max) begin
                    r_c <= r_c + INWD'(1);
                end else begin
                    r_c <= '0;
                    if (!w_f_max) r_f <= r_f + LOG_FOLD'(1);
                end
            end
        end
    end

    // Weight store is deliberately unreset; it is only read while in RUN.
    always_ff @(posedge clk) begin
        if (w_start) r_w <= weight_in;
    end

    generate
        if (FOLD > 1) begin : g_fold_mux
            assign w_grp = r_w[r_f];
        end else begin : g_fold_one
            assign w_grp = r_w[0];
        end
    endgenerate

    genvar k;
    generate
        for (k = 0; k < BEAT_W; k++) begin : g_lane
            assign out_bits[k] = (w_grp[k*INWD +: INWD] > r_c);
        end
    endgenerate

    assign out_valid = (r_state == RUN);
    assign out_fold  = r_f;
    assign out_cnt   = r_c;
    assign out_last  = out_valid && w_c_max;
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_weight_bsg_seq.sv
// Directed bench for weight_bsg_seq (DIM_OUT=4, DIM_IN=2, INWD=3, FOLD=2) with a beat scoreboard.
module tb_weight_bsg_seq;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [23:0] weight_in;
    logic        out_valid, out_last, busy, done;
    logic [3:0]  out_bits;
    logic [0:0]  out_fold;
    logic [2:0]  out_cnt;

    int          errors = 0;
    int          checks = 0;
    int          ones_r3c1 = 0;
    logic [8:0]  sb[$];

    weight_bsg_seq #(.DIM_OUT(4), .DIM_IN(2), .INWD(3), .FOLD(2)) dut (
        .clk(clk), .rst(rst), .start(start), .weight_in(weight_in),
        .out_ready(out_ready), .out_valid(out_valid), .out_bits(out_bits),
        .out_fold(out_fold), .out_cnt(out_cnt), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare any beat that will transfer at the coming edge, then advance one cycle.
    task automatic step();
        logic [8:0] e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (out_fold === 1'b1 && out_bits[3] === 1'b1) ones_r3c1++;
            if (sb.size() == 0) begin
                chk("unexpected_beat", {23'd0, out_bits, out_fold, out_cnt, out_last}, 32'h1ff);
            end else begin
                e = sb.pop_front();
                chk("beat", {23'd0, out_bits, out_fold, out_cnt, out_last}, {23'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] ramp_w();
        logic [23:0] w = '0;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 2; i++)
                w[(r*2+i)*3 +: 3] = 3'((r*2 + i) % 8);
        return w;
    endfunction

    task automatic push_frame(input logic [23:0] w);
        logic [3:0] b;
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 8; c++) begin
                for (int o = 0; o < 2; o++)
                    for (int i = 0; i < 2; i++)
                        b[o*2+i] = (int'(w[((f*2+o)*2+i)*3 +: 3]) > c);
                sb.push_back({b, 1'(f), 3'(c), (c == 7)});
            end
    endtask

    // mode 0: ready high; 1: ready toggles; 2: restart attempt at beat 5; 3: reset at beat 10
    task automatic frame(input int mode, input logic [23:0] w, input int exp_done);
        int cyc;
        weight_in = w;
        push_frame(w);
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        chk("valid_after_start", {31'd0, out_valid}, 32'd1);
        while (done !== 1'b1 && cyc < 200) begin
            if (mode == 1) out_ready = (cyc % 2 == 1);
            if (mode == 2) begin
                start = (cyc == 6);
                if (cyc == 6) weight_in = ~w;
            end
            if (mode == 3 && cyc == 11) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                sb.delete();
                chk("rst_valid", {31'd0, out_valid}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_cnt", {29'd0, out_cnt}, 32'd0);
                for (int n = 0; n < 20; n++) begin
                    step();
                    chk("no_done_after_rst", {31'd0, done}, 32'd0);
                end
                return;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        chk("done_cycle", cyc, exp_done);
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; weight_in = '0;
        step(); step();
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_last", {31'd0, out_last}, 32'd0);
        chk("reset_cnt", {29'd0, out_cnt}, 32'd0);
        chk("reset_fold", {31'd0, out_fold}, 32'd0);
        rst = 1'b0;
        step();

        // ramp weights, ready always high
        ones_r3c1 = 0;
        frame(0, ramp_w(), 17);
        chk("ones_r3c1", ones_r3c1, 32'd7);
        step();
        chk("done_pulse_one", {31'd0, done}, 32'd0);

        // ready toggling stretches the frame
        frame(1, ramp_w(), 32);
        step();

        // restart attempt mid-frame with new weights is ignored
        frame(2, ramp_w(), 17);
        step();

        // reset mid-frame, then a full frame
        frame(3, ramp_w(), 0);
        frame(0, ramp_w(), 17);
        step();

        // boundary weights
        frame(0, 24'h000000, 17);
        step();
        frame(0, 24'hffffff, 17);

        // start during the done cycle is ignored; start one cycle later is honoured
        chk("done_now", {31'd0, done}, 32'd1);
        start = 1'b1;
        step();
        chk("start_in_done_ignored", {31'd0, out_valid}, 32'd0);
        frame(0, ramp_w(), 17);
        step();
        step();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
